nv_nvdla_rt_mac2accu_pipe: RTL

- Parametrised retiming pipe for the CMAC→CACC partial-sum path. It generalises the fixed cmac_b→cacc retiming stage.
- Configurable stage count, lane count and lane width.
- Adds per-lane mask-gated data loading to save register toggle power.
- Adds an idle indication for SLCG, an in-flight occupancy count and a saturating beat counter.
- Sits inside partition A between the MAC input ports and the accumulator.

---
 rtl/nv_nvdla_rt_pkg.sv | 16 +
 rtl/nv_nvdla_rt_mac_stage.sv | 53 +++++
 rtl/nv_nvdla_rt_mac2accu_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/nv_nvdla_rt_pkg.sv
// Shared defaults and sideband type for the CMAC->CACC retiming pipe.
// Imported by the stage and top-level modules.
package nv_nvdla_rt_pkg;

   localparam int MAC_LANES  = 8;
   localparam int MAC_LANE_W = 176;
   localparam int MAC_PD_W   = 9;

   typedef struct packed {
      logic                  valid;
      logic [MAC_LANES-1:0]  mask;
      logic [MAC_LANES-1:0]  mode;
      logic [MAC_PD_W-1:0]   pd;
   } rt_sb_t;

endpackage

// File: rtl/nv_nvdla_rt_mac_stage.sv
// One retiming stage: sideband loads on valid, each data lane loads
// only on valid and its own mask bit so idle lanes do not toggle.
module nv_nvdla_rt_mac_stage
   import nv_nvdla_rt_pkg::*;
#(
   parameter int LANES  = MAC_LANES,
   parameter int LANE_W = MAC_LANE_W,
   parameter int PD_W   = MAC_PD_W
) (
   input  logic                    nvdla_core_clk,
   input  logic                    nvdla_core_rst,
   input  logic                    src_pvld,
   input  logic [LANES-1:0]        src_mask,
   input  logic [LANES-1:0]        src_mode,
   input  logic [LANES*LANE_W-1:0] src_data,
   input  logic [PD_W-1:0]         src_pd,
   output logic                    dst_pvld,
   output logic [LANES-1:0]        dst_mask,
   output logic [LANES-1:0]        dst_mode,
   output logic [LANES*LANE_W-1:0] dst_data,
   output logic [PD_W-1:0]         dst_pd
);

   logic [LANE_W-1:0] lane_q [LANES];

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         dst_pvld <= 1'b0;
         dst_mask <= '0;
         dst_mode <= '0;
         dst_pd   <= '0;
      end else begin
         dst_pvld <= src_pvld;
         if (src_pvld) begin
            dst_mask <= src_mask;
            dst_mode <= src_mode;
            dst_pd   <= src_pd;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      always_ff @(posedge nvdla_core_clk) begin
         if (nvdla_core_rst) begin
            lane_q[i] <= '0;
         end else if (src_pvld && src_mask[i]) begin
            lane_q[i] <= src_data[i*LANE_W +: LANE_W];
         end
      end
      assign dst_data[i*LANE_W +: LANE_W] = lane_q[i];
   end

endmodule

// File: rtl/nv_nvdla_rt_mac2accu_pipe.sv
// Parametrised CMAC->CACC partial-sum retiming pipe with occupancy,
// SLCG idle indication and a saturating output beat counter.
module nv_nvdla_rt_mac2accu_pipe
   import nv_nvdla_rt_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int LANES  = MAC_LANES,
   parameter int LANE_W = MAC_LANE_W,
   parameter int PD_W   = MAC_PD_W,
   parameter int CNT_W  = 32,
   // DEPTH=0 would give a zero-width count, so keep at least one bit
   localparam int IW = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
   input  logic                    nvdla_core_clk,
   input  logic                    nvdla_core_rst,
   input  logic                    src_pvld,
   input  logic [LANES-1:0]        src_mask,
   input  logic [LANES-1:0]        src_mode,
   input  logic [LANES*LANE_W-1:0] src_data,
   input  logic [PD_W-1:0]         src_pd,
   output logic                    dst_pvld,
   output logic [LANES-1:0]        dst_mask,
   output logic [LANES-1:0]        dst_mode,
   output logic [LANES*LANE_W-1:0] dst_data,
   output logic [PD_W-1:0]         dst_pd,
   output logic [IW-1:0]           pipe_inflight,
   output logic                    pipe_idle,
   input  logic                    stat_clr,
   output logic [CNT_W-1:0]        stat_beats
);

   logic                    pvld_s [DEPTH+1];
   logic [LANES-1:0]        mask_s [DEPTH+1];
   logic [LANES-1:0]        mode_s [DEPTH+1];
   logic [LANES*LANE_W-1:0] data_s [DEPTH+1];
   logic [PD_W-1:0]         pd_s   [DEPTH+1];

   assign pvld_s[0] = src_pvld;
   assign mask_s[0] = src_mask;
   assign mode_s[0] = src_mode;
   assign data_s[0] = src_data;
   assign pd_s[0]   = src_pd;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      nv_nvdla_rt_mac_stage #(
         .LANES  (LANES),
         .LANE_W (LANE_W),
         .PD_W   (PD_W)
      ) u_stage (
         .nvdla_core_clk (nvdla_core_clk),
         .nvdla_core_rst (nvdla_core_rst),
         .src_pvld       (pvld_s[k-1]),
         .src_mask       (mask_s[k-1]),
         .src_mode       (mode_s[k-1]),
         .src_data       (data_s[k-1]),
         .src_pd         (pd_s[k-1]),
         .dst_pvld       (pvld_s[k]),
         .dst_mask       (mask_s[k]),
         .dst_mode       (mode_s[k]),
         .dst_data       (data_s[k]),
         .dst_pd         (pd_s[k])
      );
   end

   assign dst_pvld = pvld_s[DEPTH];
   assign dst_mask = mask_s[DEPTH];
   assign dst_mode = mode_s[DEPTH];
   assign dst_data = data_s[DEPTH];
   assign dst_pd   = pd_s[DEPTH];

   always_comb begin
      pipe_inflight = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         pipe_inflight = pipe_inflight + IW'(pvld_s[k]);
      end
   end

   // Feeds the SLCG enable, so it must also see the beat entering now
   assign pipe_idle = (pipe_inflight == '0) && !src_pvld;

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst || stat_clr) begin
         stat_beats <= '0;
      end else if (dst_pvld && (stat_beats != '1)) begin
         stat_beats <= stat_beats + CNT_W'(1);
      end
   end

endmodule
